// File: rtl/iq_alloc_ctrl.sv
// Issue-queue slot allocator: circular free-slot search from a one-hot base
// pointer, multi-lane enqueue, multi-hot dequeue, masked flush with a
// one-cycle pointer realignment afterwards.
module iq_alloc_ctrl #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ENQ_WIDTH = 2,
  parameter int unsigned MODE      = 0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic [DEPTH-1:0]             flush_mask,
  input  logic [ENQ_WIDTH-1:0]         enq_req,
  output logic [ENQ_WIDTH-1:0]         enq_ready,
  output logic [ENQ_WIDTH-1:0]         enq_fire,
  output logic [ENQ_WIDTH*DEPTH-1:0]   enq_slot_oh,
  input  logic [DEPTH-1:0]             deq_oh,
  output logic [DEPTH-1:0]             valid_vec,
  output logic [DEPTH-1:0]             enq_ptr_oh,
  output logic [$clog2(DEPTH+1)-1:0]   free_cnt,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             flush_q;

  logic [PW-1:0]                     base_idx;
  logic [DEPTH-1:0]                  free_rot;
  logic [ENQ_WIDTH-1:0][DEPTH-1:0]   rot_cand;
  logic [ENQ_WIDTH-1:0][DEPTH-1:0]   lane_slot;
  logic [DEPTH-1:0]                  enq_set;
  logic [DEPTH-1:0]                  last_slot;
  logic [DEPTH-1:0]                  realign;
  logic [CW-1:0]                     fire_cnt;

  function automatic logic [CW-1:0] popcnt(input logic [DEPTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Encode the base pointer and rotate the free map so bit 0 is the base slot.
  always_comb begin
    base_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ptr_q[i]) base_idx = PW'(i);
    end
    free_rot = DEPTH'({~valid_q, ~valid_q} >> base_idx);
  end

  // Hand the i-th free slot (in rotated order) to lane i, then rotate back.
  always_comb begin
    int found;
    found    = 0;
    rot_cand = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (free_rot[k]) begin
        for (int l = 0; l < ENQ_WIDTH; l++) begin
          if (found == l) rot_cand[l][k] = 1'b1;
        end
        found = found + 1;
      end
    end
    for (int l = 0; l < ENQ_WIDTH; l++) begin
      lane_slot[l] = DEPTH'(({rot_cand[l], rot_cand[l]} << base_idx) >> DEPTH);
    end
  end

  // Per-lane ready/fire and slot outputs; not-ready lanes drive zero.
  always_comb begin
    enq_set   = '0;
    last_slot = '0;
    fire_cnt  = '0;
    for (int l = 0; l < ENQ_WIDTH; l++) begin
      enq_ready[l] = (cnt_q > CW'(l)) & ~flush & ~flush_q;
      enq_fire[l]  = enq_req[l] & enq_ready[l];
      enq_slot_oh[l*DEPTH +: DEPTH] = enq_ready[l] ? lane_slot[l] : '0;
      if (enq_fire[l]) begin
        enq_set   = enq_set | lane_slot[l];
        last_slot = lane_slot[l];
        fire_cnt  = fire_cnt + CW'(1);
      end
    end
  end

  // Next occupancy and free count; flush only kills slots while flush is high.
  always_comb begin
    valid_d = (valid_q | enq_set) & ~deq_oh & ~(flush ? flush_mask : '0);
    cnt_d   = cnt_q + popcnt(deq_oh & valid_q)
            + (flush ? popcnt(flush_mask & valid_q & ~deq_oh) : CW'(0))
            - fire_cnt;
  end

  // Next pointer: advance past last fired slot, empty realign, post-flush reload.
  always_comb begin
    realign    = '0;
    realign[0] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_d[i]) begin
        realign = '0;
        realign[(i + 1) % DEPTH] = 1'b1;
      end
    end
    if (|enq_fire) ptr_d = {last_slot[DEPTH-2:0], last_slot[DEPTH-1]};
    else           ptr_d = ptr_q;
    if (MODE == 0 && valid_d == '0) begin
      ptr_d    = '0;
      ptr_d[0] = 1'b1;
    end
    if (flush_q) ptr_d = realign;
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      ptr_q   <= DEPTH'(1);
      cnt_q   <= CW'(DEPTH);
      flush_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      flush_q <= flush;
    end
  end

  assign valid_vec  = valid_q;
  assign enq_ptr_oh = ptr_q;
  assign free_cnt   = cnt_q;
  assign full       = (cnt_q == '0);
  assign empty      = (cnt_q == CW'(DEPTH));

`ifndef SYNTHESIS
  logic lane_overlap;

  // Any two lanes claiming the same slot is an allocator bug.
  always_comb begin
    lane_overlap = 1'b0;
    for (int a = 0; a < ENQ_WIDTH; a++) begin
      for (int b = a + 1; b < ENQ_WIDTH; b++) begin
        if ((enq_slot_oh[a*DEPTH +: DEPTH] & enq_slot_oh[b*DEPTH +: DEPTH]) != '0)
          lane_overlap = 1'b1;
      end
    end
  end

  a_cnt_consistent: assert property (@(posedge clock) disable iff (!reset_n)
    cnt_q == CW'(DEPTH - $countones(valid_q)));
  a_deq_valid: assert property (@(posedge clock) disable iff (!reset_n)
    (deq_oh & ~valid_q) == '0);
  a_req_contig: assert property (@(posedge clock) disable iff (!reset_n)
    (ENQ_WIDTH'(enq_req + 1'b1) & enq_req) == '0);
  a_no_overlap: assert property (@(posedge clock) disable iff (!reset_n)
    !lane_overlap);
`endif

endmodule

// File: tb/tb_iq_alloc_ctrl.sv
// Directed bench for iq_alloc_ctrl: DEPTH=8, ENQ_WIDTH=2. A MODE=0 and a
// MODE=1 instance share stimulus; only the empty-pointer behaviour differs.
module tb_iq_alloc_ctrl;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic [7:0]  flush_mask;
  logic [1:0]  enq_req;
  logic [7:0]  deq_oh;

  logic [1:0]  ready0, fire0, ready1, fire1;
  logic [15:0] slot0, slot1;
  logic [7:0]  valid0, ptr0, valid1, ptr1;
  logic [3:0]  cnt0, cnt1;
  logic        full0, empty0, full1, empty1;
  logic [7:0]  lane0, lane1;

  int checks;
  int errors;

  assign lane0 = slot0[7:0];
  assign lane1 = slot0[15:8];

  iq_alloc_ctrl #(.DEPTH(8), .ENQ_WIDTH(2), .MODE(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .flush_mask(flush_mask),
    .enq_req(enq_req), .enq_ready(ready0), .enq_fire(fire0), .enq_slot_oh(slot0),
    .deq_oh(deq_oh), .valid_vec(valid0), .enq_ptr_oh(ptr0), .free_cnt(cnt0),
    .full(full0), .empty(empty0)
  );

  iq_alloc_ctrl #(.DEPTH(8), .ENQ_WIDTH(2), .MODE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .flush(flush), .flush_mask(flush_mask),
    .enq_req(enq_req), .enq_ready(ready1), .enq_fire(fire1), .enq_slot_oh(slot1),
    .deq_oh(deq_oh), .valid_vec(valid1), .enq_ptr_oh(ptr1), .free_cnt(cnt1),
    .full(full1), .empty(empty1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [7:0] deq,
                       input logic fl, input logic [7:0] fm);
    enq_req    = req;
    deq_oh     = deq;
    flush      = fl;
    flush_mask = fm;
  endtask

  task automatic do_reset();
    drive(2'b00, 8'h00, 1'b0, 8'h00);
    reset_n = 1'b0;
    #3;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(2'b00, 8'h00, 1'b0, 8'h00);
    reset_n = 1'b0;
    #1;
    checks++; if (valid0 !== 8'h00) begin errors++; $display("FAIL reset_valid got %h exp 00", valid0); end
    checks++; if (ptr0 !== 8'h01) begin errors++; $display("FAIL reset_ptr got %h exp 01", ptr0); end
    checks++; if (cnt0 !== 4'd8) begin errors++; $display("FAIL reset_cnt got %0d exp 8", cnt0); end
    checks++; if ({empty0, full0} !== 2'b10) begin errors++; $display("FAIL reset_empty_full got %b exp 10", {empty0, full0}); end
    checks++; if (ready0 !== 2'b11) begin errors++; $display("FAIL reset_ready got %b exp 11", ready0); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_basic_enq();
    do_reset();
    drive(2'b11, 8'h00, 1'b0, 8'h00);
    #1;
    checks++; if (lane0 !== 8'h01) begin errors++; $display("FAIL basic_lane0 got %h exp 01", lane0); end
    checks++; if (lane1 !== 8'h02) begin errors++; $display("FAIL basic_lane1 got %h exp 02", lane1); end
    checks++; if (fire0 !== 2'b11) begin errors++; $display("FAIL basic_fire got %b exp 11", fire0); end
    tick();
    checks++; if (valid0 !== 8'h03) begin errors++; $display("FAIL basic_valid got %h exp 03", valid0); end
    checks++; if (ptr0 !== 8'h04) begin errors++; $display("FAIL basic_ptr got %h exp 04", ptr0); end
    checks++; if (cnt0 !== 4'd6) begin errors++; $display("FAIL basic_cnt got %0d exp 6", cnt0); end
    drive(2'b00, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_fill_wrap();
    do_reset();
    drive(2'b11, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) tick();
    drive(2'b00, 8'h00, 1'b0, 8'h00);
    #1;
    checks++; if (valid0 !== 8'hFF) begin errors++; $display("FAIL fill_valid got %h exp ff", valid0); end
    checks++; if (full0 !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full0); end
    checks++; if (ready0 !== 2'b00) begin errors++; $display("FAIL fill_ready got %b exp 00", ready0); end
    checks++; if (ptr0 !== 8'h01) begin errors++; $display("FAIL fill_ptr got %h exp 01", ptr0); end
    drive(2'b00, 8'h05, 1'b0, 8'h00);
    tick();
    checks++; if (cnt0 !== 4'd2) begin errors++; $display("FAIL deq_cnt got %0d exp 2", cnt0); end
    checks++; if (valid0 !== 8'hFA) begin errors++; $display("FAIL deq_valid got %h exp fa", valid0); end
    drive(2'b11, 8'h00, 1'b0, 8'h00);
    #1;
    checks++; if (lane0 !== 8'h01) begin errors++; $display("FAIL refill_lane0 got %h exp 01", lane0); end
    checks++; if (lane1 !== 8'h04) begin errors++; $display("FAIL refill_lane1 got %h exp 04", lane1); end
    tick();
    drive(2'b00, 8'h00, 1'b0, 8'h00);
    checks++; if (ptr0 !== 8'h08) begin errors++; $display("FAIL refill_ptr got %h exp 08", ptr0); end
    checks++; if (valid0 !== 8'hFF) begin errors++; $display("FAIL refill_valid got %h exp ff", valid0); end
  endtask

  // Continues from the full queue left by test_fill_wrap (pointer at slot 3).
  task automatic test_partial();
    drive(2'b00, 8'h01, 1'b0, 8'h00);
    tick();
    checks++; if (cnt0 !== 4'd1) begin errors++; $display("FAIL partial_cnt got %0d exp 1", cnt0); end
    drive(2'b11, 8'h00, 1'b0, 8'h00);
    #1;
    checks++; if (fire0 !== 2'b01) begin errors++; $display("FAIL partial_fire got %b exp 01", fire0); end
    checks++; if (lane1 !== 8'h00) begin errors++; $display("FAIL partial_lane1 got %h exp 00", lane1); end
    checks++; if (lane0 !== 8'h01) begin errors++; $display("FAIL partial_lane0 got %h exp 01", lane0); end
    tick();
    drive(2'b00, 8'h00, 1'b0, 8'h00);
    checks++; if (ptr0 !== 8'h02) begin errors++; $display("FAIL partial_ptr got %h exp 02", ptr0); end
    checks++; if (cnt0 !== 4'd0) begin errors++; $display("FAIL partial_cnt_after got %0d exp 0", cnt0); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(2'b11, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) tick();
    drive(2'b00, 8'h00, 1'b1, 8'h30);
    #1;
    checks++; if (valid0 !== 8'h3F) begin errors++; $display("FAIL flush_pre_valid got %h exp 3f", valid0); end
    checks++; if (ptr0 !== 8'h40) begin errors++; $display("FAIL flush_pre_ptr got %h exp 40", ptr0); end
    checks++; if (ready0 !== 2'b00) begin errors++; $display("FAIL flush_ready0 got %b exp 00", ready0); end
    tick();
    drive(2'b00, 8'h00, 1'b0, 8'h00);
    checks++; if (valid0 !== 8'h0F) begin errors++; $display("FAIL flush_valid got %h exp 0f", valid0); end
    checks++; if (cnt0 !== 4'd4) begin errors++; $display("FAIL flush_cnt got %0d exp 4", cnt0); end
    checks++; if (ready0 !== 2'b00) begin errors++; $display("FAIL flush_ready1 got %b exp 00", ready0); end
    checks++; if (ptr0 !== 8'h40) begin errors++; $display("FAIL flush_ptr_hold got %h exp 40", ptr0); end
    tick();
    checks++; if (ptr0 !== 8'h10) begin errors++; $display("FAIL flush_realign got %h exp 10", ptr0); end
    checks++; if (ready0 !== 2'b11) begin errors++; $display("FAIL flush_ready2 got %b exp 11", ready0); end
  endtask

  // Continues from test_flush: valid 0x0F, pointer at slot 4.
  task automatic test_back_to_back();
    drive(2'b11, 8'h03, 1'b0, 8'h00);
    #1;
    checks++; if (lane0 !== 8'h10) begin errors++; $display("FAIL b2b_lane0 got %h exp 10", lane0); end
    checks++; if (lane1 !== 8'h20) begin errors++; $display("FAIL b2b_lane1 got %h exp 20", lane1); end
    tick();
    drive(2'b00, 8'h00, 1'b0, 8'h00);
    checks++; if (valid0 !== 8'h3C) begin errors++; $display("FAIL b2b_valid got %h exp 3c", valid0); end
    checks++; if (cnt0 !== 4'd4) begin errors++; $display("FAIL b2b_cnt got %0d exp 4", cnt0); end
    checks++; if (ptr0 !== 8'h40) begin errors++; $display("FAIL b2b_ptr got %h exp 40", ptr0); end
  endtask

  task automatic test_empty_mode();
    do_reset();
    drive(2'b11, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) tick();
    drive(2'b00, 8'h0F, 1'b0, 8'h00);
    tick();
    checks++; if (valid0 !== 8'h30) begin errors++; $display("FAIL empty_pre_valid got %h exp 30", valid0); end
    checks++; if (ptr1 !== 8'h40) begin errors++; $display("FAIL empty_pre_ptr1 got %h exp 40", ptr1); end
    drive(2'b00, 8'h30, 1'b0, 8'h00);
    tick();
    drive(2'b00, 8'h00, 1'b0, 8'h00);
    checks++; if (empty0 !== 1'b1) begin errors++; $display("FAIL empty_flag got %b exp 1", empty0); end
    checks++; if (ptr0 !== 8'h01) begin errors++; $display("FAIL empty_ptr_mode0 got %h exp 01", ptr0); end
    checks++; if (ptr1 !== 8'h40) begin errors++; $display("FAIL empty_ptr_mode1 got %h exp 40", ptr1); end
    checks++; if (cnt1 !== 4'd8) begin errors++; $display("FAIL empty_cnt_mode1 got %0d exp 8", cnt1); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(2'b11, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) tick();
    drive(2'b00, 8'h55, 1'b0, 8'h00);
    tick();
    drive(2'b00, 8'h00, 1'b1, 8'h00);
    tick();
    drive(2'b00, 8'h00, 1'b0, 8'h00);
    #1;
    checks++; if (valid0 !== 8'hAA) begin errors++; $display("FAIL arst_pre_valid got %h exp aa", valid0); end
    checks++; if (ready0 !== 2'b00) begin errors++; $display("FAIL arst_pre_ready got %b exp 00", ready0); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (valid0 !== 8'h00) begin errors++; $display("FAIL arst_valid got %h exp 00", valid0); end
    checks++; if (cnt0 !== 4'd8) begin errors++; $display("FAIL arst_cnt got %0d exp 8", cnt0); end
    checks++; if (ptr0 !== 8'h01) begin errors++; $display("FAIL arst_ptr got %h exp 01", ptr0); end
    checks++; if (ready0 !== 2'b11) begin errors++; $display("FAIL arst_ready got %b exp 11", ready0); end
    reset_n = 1'b1;
    drive(2'b11, 8'h00, 1'b0, 8'h00);
    #1;
    checks++; if (lane0 !== 8'h01) begin errors++; $display("FAIL arst_lane0 got %h exp 01", lane0); end
    tick();
    drive(2'b00, 8'h00, 1'b0, 8'h00);
    checks++; if (valid0 !== 8'h03) begin errors++; $display("FAIL arst_post_valid got %h exp 03", valid0); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b1;
    drive(2'b00, 8'h00, 1'b0, 8'h00);
    #2;
    test_reset();
    test_basic_enq();
    test_fill_wrap();
    test_partial();
    test_flush();
    test_back_to_back();
    test_empty_mode();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iq_alloc_ctrl.md
IQ_ALLOC_CTRL -- requirements
Module: iq_alloc_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, the number of issue-queue slots (range 4..64).
REQ-002 SHALL have parameter ENQ_WIDTH, default 2, the number of enqueue lanes per cycle (range 1..4, at most DEPTH).
REQ-003 SHALL have parameter MODE, default 0: 0 = realign pointer to slot 0 on empty; 1 = keep pointer on empty.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  kill the slots selected by flush_mask this cycle.
REQ-007 flush_mask  input  DEPTH  slots to invalidate when flush=1.
REQ-008 enq_req  input  ENQ_WIDTH  per-lane enqueue request; must be prefix-contiguous from lane 0.
REQ-009 enq_ready  output  ENQ_WIDTH  per-lane ready.
REQ-010 enq_fire  output  ENQ_WIDTH  per-lane accept, equal to enq_req & enq_ready.
REQ-011 enq_slot_oh  output  ENQ_WIDTH*DEPTH  one-hot slot for each lane; lane i occupies bits [i*DEPTH +: DEPTH].
REQ-012 deq_oh  input  DEPTH  multi-hot set of slots issued (freed) this cycle.
REQ-013 valid_vec  output  DEPTH  registered slot occupancy.
REQ-014 enq_ptr_oh  output  DEPTH  registered one-hot allocation base.
REQ-015 free_cnt  output  $clog2(DEPTH+1)  registered free-slot count.
REQ-016 full, empty  output  1 each  free_cnt==0 and free_cnt==DEPTH respectively.

Function
REQ-017 Allocation SHALL scan valid_vec circularly, starting at enq_ptr_oh inclusive; lane i SHALL receive the i-th free slot found; everything is combinational from registered state.
REQ-018 enq_ready[i] SHALL equal (free_cnt > i) & ~flush & ~flush_q, where flush_q is flush registered by one cycle.
REQ-019 A lane that is not ready SHALL drive all-zero enq_slot_oh.
REQ-020 Each fired lane SHALL set its slot in valid_vec at the next edge.
REQ-021 Each set bit of deq_oh SHALL clear its slot at the next edge; a slot freed in cycle N becomes allocatable only in cycle N+1.
REQ-022 Enqueue and dequeue in the same cycle SHALL both apply; they never touch the same slot.
REQ-023 After enqueue, enq_ptr_oh SHALL move to the slot circularly after the last fired lane's slot (wraps DEPTH-1 to 0); with no fire it holds.
REQ-024 If valid_vec becomes 0 at the next edge: MODE 0 sets enq_ptr_oh to 1 (slot 0); MODE 1 applies REQ-023.
REQ-025 With flush=1, valid_vec SHALL clear the flush_mask slots at the next edge; dequeue still applies; no enqueue fires.
REQ-026 In the cycle where flush_q=1, enq_ptr_oh SHALL load the slot after the highest-index surviving valid slot (DEPTH-1 wraps to 0), or slot 0 if none survive. This load overrides REQ-023 and REQ-024.
REQ-027 A flush during flush_q SHALL apply REQ-025 and restart the one-cycle realignment.
REQ-028 free_cnt SHALL update as free_cnt + popcount(deq_oh & valid_vec) + popcount(flush_mask & valid_vec & ~deq_oh) - popcount(enq_fire).
REQ-029 free_cnt SHALL always equal DEPTH - popcount(valid_vec); an assertion checks this.
REQ-030 Assertions SHALL flag: deq_oh on an invalid slot; non-contiguous enq_req; overlapping enq_slot_oh between lanes.

Reset
REQ-031 With reset_n=0, asynchronously: valid_vec=0, enq_ptr_oh=1, free_cnt=DEPTH, flush_q=0, hence empty=1, full=0, enq_ready=all-1.
REQ-032 Reset asserted mid-operation SHALL discard all state; the first post-reset cycle behaves as REQ-031 regardless of prior flush.

Verification (DEPTH=8, ENQ_WIDTH=2, MODE=0 unless stated)
REQ-033 Reset, then enq_req=11 -> enq_slot_oh lane0=0x01, lane1=0x02; next cycle valid_vec=0x03, enq_ptr_oh=0x04, free_cnt=6.
REQ-034 Four cycles of enq_req=11 -> valid_vec=0xFF, full=1, enq_ready=00, enq_ptr_oh=0x01. Then deq_oh=0x05 -> free_cnt=2. Then enq_req=11 -> slots 0x01 and 0x04 allocated, enq_ptr_oh=0x08.
REQ-035 valid_vec=0x3F, enq_ptr_oh=0x40, flush=1, flush_mask=0x30 -> valid_vec=0x0F, enq_ready=00 for 2 cycles, enq_ptr_oh=0x10 after the flush_q cycle, free_cnt=4.
REQ-036 free_cnt=1, enq_req=11 -> enq_fire=01 only; lane1 enq_slot_oh=0.
REQ-037 valid_vec=0x30, enq_ptr_oh=0x40, deq_oh=0x30 -> empty=1, enq_ptr_oh=0x01 (MODE 0); same stimulus with MODE=1 -> enq_ptr_oh stays 0x40.
REQ-038 reset_n pulsed low while valid_vec=0xAA and flush_q=1 -> immediately valid_vec=0, free_cnt=8, enq_ptr_oh=0x01.
